mux_rr_arbiter: RTL and testbench

Two-channel round-robin arbiter and one-entry output register that sits directly upstream of the 4-bit 2:1 simplemux. It accepts beats from sources A and B over valid/ready handshakes and decides which source is forwarded. It drives the mux-style select (se) and enable (en) lines plus a registered copy of the selected data (c_data), so c_data always equals what simplemux would output for the same a, b, se and en. Per-channel beat counters are provided for debug and verification.

---
 rtl/mux_rr_arbiter_if.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 91 +++++++++
 tb/tb_mux_rr_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - handshake bundle between two sources, the arbiter and the simplemux side
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] c_data;
    logic             c_valid;
    logic             c_ready;
    logic             se;
    logic             en;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;

    // Drives sources and downstream ready, observes everything the arbiter produces.
    modport master (
        output a_data, a_valid, b_data, b_valid, c_ready,
        input  a_ready, b_ready, c_data, c_valid, se, en, a_cnt, b_cnt
    );

    // The arbiter itself.
    modport slave (
        input  a_data, a_valid, b_data, b_valid, c_ready,
        output a_ready, b_ready, c_data, c_valid, se, en, a_cnt, b_cnt
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-channel round-robin arbiter with one-entry output register
module mux_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             grant_a;
    logic             grant_b;
    logic             last_grant_b;
    logic [WIDTH-1:0] c_data_q;
    logic             se_q;
    logic [CNT_W-1:0] a_cnt_q;
    logic [CNT_W-1:0] b_cnt_q;

    // The slot can take a new beat when empty or when the held beat leaves this cycle.
    assign load = (state_q == ST_EMPTY) || bus.c_ready;

    // Round-robin pick: contested cycles go to the channel not granted last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (load) begin
            if (bus.a_valid && (!bus.b_valid || last_grant_b)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    // Output register occupancy: refilled on a grant, emptied when freed without one.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (grant_a || grant_b) ? ST_FULL : ST_EMPTY;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data, select, fairness pointer and beat counters; an ungranted free slot
    // clears c_data so it matches a disabled simplemux, while se keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_data_q     <= '0;
            se_q         <= 1'b0;
            last_grant_b <= 1'b1;
            a_cnt_q      <= '0;
            b_cnt_q      <= '0;
        end else if (grant_a) begin
            c_data_q     <= bus.a_data;
            se_q         <= 1'b0;
            last_grant_b <= 1'b0;
            a_cnt_q      <= a_cnt_q + 1'b1;
        end else if (grant_b) begin
            c_data_q     <= bus.b_data;
            se_q         <= 1'b1;
            last_grant_b <= 1'b1;
            b_cnt_q      <= b_cnt_q + 1'b1;
        end else if (load) begin
            c_data_q     <= '0;
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
    assign bus.c_data  = c_data_q;
    assign bus.c_valid = (state_q == ST_FULL);
    assign bus.en      = (state_q == ST_FULL);
    assign bus.se      = se_q;
    assign bus.a_cnt   = a_cnt_q;
    assign bus.b_cnt   = b_cnt_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [4:0] exp_q[$];

    mux_rr_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus ();

    mux_rr_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, and each beat consumed downstream is checked against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("en_eq_valid", {31'd0, bus.en}, {31'd0, bus.c_valid});
            if (!bus.c_valid) check("idle_data_zero", {28'd0, bus.c_data}, 32'd0);
            if (bus.c_valid && bus.c_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {27'd0, bus.se, bus.c_data}, 32'hffff_ffff);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", {28'd0, bus.c_data}, {28'd0, e[3:0]});
                    check("beat_se", {31'd0, bus.se}, {31'd0, e[4]});
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq_d[4];
        logic       seq_s[4];
        total = 0;
        bad   = 0;
        bus.a_data  = '0;
        bus.a_valid = 1'b0;
        bus.b_data  = '0;
        bus.b_valid = 1'b0;
        bus.c_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_c_valid", {31'd0, bus.c_valid}, 32'd0);
        check("rst_en", {31'd0, bus.en}, 32'd0);
        check("rst_se", {31'd0, bus.se}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Single channel A for three cycles
        bus.a_data  = 4'b1010;
        bus.a_valid = 1'b1;
        bus.c_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("single_a_ready", {31'd0, bus.a_ready}, 32'd1);
            check("single_b_ready", {31'd0, bus.b_ready}, 32'd0);
            exp_q.push_back({1'b0, 4'b1010});
            next_cycle();
            check("single_en", {31'd0, bus.en}, 32'd1);
            check("single_se", {31'd0, bus.se}, 32'd0);
        end
        bus.a_valid = 1'b0;
        bus.c_ready = 1'b0;
        #1;
        check("single_a_cnt", {24'd0, bus.a_cnt}, 32'd3);
        check("single_b_cnt", {24'd0, bus.b_cnt}, 32'd0);
        check("full_c_data", {28'd0, bus.c_data}, 32'hA);

        // Asynchronous reset mid-cycle while FULL
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_c_valid", {31'd0, bus.c_valid}, 32'd0);
        check("async_en", {31'd0, bus.en}, 32'd0);
        check("async_se", {31'd0, bus.se}, 32'd0);
        check("async_c_data", {28'd0, bus.c_data}, 32'd0);
        check("async_a_cnt", {24'd0, bus.a_cnt}, 32'd0);
        check("async_b_cnt", {24'd0, bus.b_cnt}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Contention from reset: A,B,A,B
        seq_d[0] = 4'b1111; seq_s[0] = 1'b0;
        seq_d[1] = 4'b0000; seq_s[1] = 1'b1;
        seq_d[2] = 4'b1111; seq_s[2] = 1'b0;
        seq_d[3] = 4'b0000; seq_s[3] = 1'b1;
        bus.a_data  = 4'b1111;
        bus.b_data  = 4'b0000;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.c_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_a_ready", {31'd0, bus.a_ready}, {31'd0, ~seq_s[i]});
            check("cont_b_ready", {31'd0, bus.b_ready}, {31'd0, seq_s[i]});
            exp_q.push_back({seq_s[i], seq_d[i]});
            next_cycle();
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #1;
        check("cont_a_cnt", {24'd0, bus.a_cnt}, 32'd2);
        check("cont_b_cnt", {24'd0, bus.b_cnt}, 32'd2);

        // Drain: no valids with c_ready high empties the slot, se holds B
        next_cycle();
        check("drain_c_valid", {31'd0, bus.c_valid}, 32'd0);
        check("drain_en", {31'd0, bus.en}, 32'd0);
        check("drain_c_data", {28'd0, bus.c_data}, 32'd0);
        check("drain_se", {31'd0, bus.se}, 32'd1);

        // Backpressure: load a B beat, then stall with both valid
        bus.b_data  = 4'b0101;
        bus.b_valid = 1'b1;
        #1;
        check("bp_load_b_ready", {31'd0, bus.b_ready}, 32'd1);
        exp_q.push_back({1'b1, 4'b0101});
        next_cycle();
        bus.a_data  = 4'b0011;
        bus.a_valid = 1'b1;
        bus.c_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_a_ready", {31'd0, bus.a_ready}, 32'd0);
            check("bp_b_ready", {31'd0, bus.b_ready}, 32'd0);
            check("bp_c_data", {28'd0, bus.c_data}, 32'h5);
            check("bp_se", {31'd0, bus.se}, 32'd1);
            check("bp_en", {31'd0, bus.en}, 32'd1);
            check("bp_a_cnt", {24'd0, bus.a_cnt}, 32'd2);
            check("bp_b_cnt", {24'd0, bus.b_cnt}, 32'd3);
            next_cycle();
        end
        bus.c_ready = 1'b1;
        #1;
        check("release_a_ready", {31'd0, bus.a_ready}, 32'd1);
        check("release_b_ready", {31'd0, bus.b_ready}, 32'd0);
        exp_q.push_back({1'b0, 4'b0011});
        next_cycle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        next_cycle();
        check("release_a_cnt", {24'd0, bus.a_cnt}, 32'd3);

        // Wrap: 256 back-to-back A beats from reset
        do_reset();
        bus.a_valid = 1'b1;
        bus.c_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.a_data = i[3:0] ^ i[7:4];
            exp_q.push_back({1'b0, i[3:0] ^ i[7:4]});
            next_cycle();
            if (i == 254) check("wrap_a_cnt_255", {24'd0, bus.a_cnt}, 32'd255);
        end
        bus.a_valid = 1'b0;
        #1;
        check("wrap_a_cnt_0", {24'd0, bus.a_cnt}, 32'd0);
        check("wrap_b_cnt", {24'd0, bus.b_cnt}, 32'd0);
        next_cycle();
        next_cycle();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
